dmem_arbiter: RTL

//   Two-port arbiter/sequencer in front of the word-addressed data memory (WE/WD/A/RD).

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer in front of the word-addressed data memory.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 wins ties.
module dmem_arbiter #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter logic [31:0] ADDR_LAST   = 32'h8000_03FC,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        sel_q;
  logic        we_q;
  logic        ok_q;
  logic        m0_gnt_q, m1_gnt_q;
  logic        m0_rvalid_q, m1_rvalid_q;
  logic        m0_err_q, m1_err_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic        mem_we_q;
  logic [31:0] mem_a_q, mem_wd_q;

  logic        win_valid_d;
  logic        win_port_d;
  logic        win_we_d;
  logic [31:0] win_addr_d;
  logic [31:0] win_wdata_d;
  logic        win_ok_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic        rr_last_q;
`endif

  // Winner selection; win_port_d = 1 means port 1.
  always_comb begin
    win_valid_d = m0_req | m1_req;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    win_port_d  = (m0_req & m1_req) ? ~rr_last_q : m1_req;
`else
    win_port_d  = ~m0_req;
`endif
    win_we_d    = win_port_d ? m1_we    : m0_we;
    win_addr_d  = win_port_d ? m1_addr  : m0_addr;
    win_wdata_d = win_port_d ? m1_wdata : m0_wdata;
    win_ok_d    = (win_addr_d >= ADDR_BASE) && (win_addr_d <= ADDR_LAST) &&
                  (win_addr_d[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      ok_q        <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_a_q     <= 32'h0;
      mem_wd_q    <= 32'h0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          mem_a_q  <= 32'h0;
          mem_wd_q <= 32'h0;
          state_q  <= IDLE;
          if (win_valid_d) begin
            state_q  <= ACCESS;
            cnt_q    <= WS_CNT;
            sel_q    <= win_port_d;
            we_q     <= win_we_d;
            ok_q     <= win_ok_d;
            m0_gnt_q <= ~win_port_d;
            m1_gnt_q <= win_port_d;
            mem_a_q  <= win_addr_d;
            mem_wd_q <= win_wdata_d;
            // With no wait states the first ACCESS cycle is also the last one.
            mem_we_q <= win_we_d & win_ok_d & (WS_CNT == 4'd0);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_last_q <= win_port_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q  <= RESP;
            mem_a_q  <= 32'h0;
            mem_wd_q <= 32'h0;
            if (sel_q) begin
              m1_rvalid_q <= 1'b1;
              m1_err_q    <= ~ok_q;
              m1_rdata_q  <= (ok_q & ~we_q) ? mem_rd : 32'h0;
            end else begin
              m0_rvalid_q <= 1'b1;
              m0_err_q    <= ~ok_q;
              m0_rdata_q  <= (ok_q & ~we_q) ? mem_rd : 32'h0;
            end
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            mem_we_q <= we_q & ok_q & (cnt_q == 4'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m0_err    = m0_err_q;
  assign m1_gnt    = m1_gnt_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_err    = m1_err_q;
  // A write strobe never reaches the memory on a cycle in which reset is asserted.
  assign mem_we    = mem_we_q & ~rst;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;

endmodule
